// File: rtl/pattern_pkg.sv
// Shared constants, FSM encoding and field addressing for the pattern bank.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package pattern_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_BUFSIZE = 24;
  localparam int DEF_NBUF    = 8;
  localparam int DEF_NSEQ    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Field 0 lives in the top WIDTH bits of a flattened vector, so the bit
  // offset of field k counts down from the top.
  function automatic int field_lsb(input int k, input int nfields, input int width);
    return (nfields - 1 - k) * width;
  endfunction

endpackage

// File: rtl/pattern_dbuf.sv
// One double-buffered register: serial shadow shift register plus active copy.
// Latency: commit strobe copies shadow into active at the next clock edge.
// Backpressure: none; the parent sequences preload/shift/commit.
// Ports: clk/rst_n; preload (first bit of a frame, seeds shadow from active),
//        shift (subsequent bits), commit (shadow -> active), sin (serial bit),
//        active (committed contents), shadow_msb (serial readback bit).
module pattern_dbuf #(
  parameter int LEN = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           preload,
  input  logic           shift,
  input  logic           commit,
  input  logic           sin,
  output logic [LEN-1:0] active,
  output logic           shadow_msb
);

  logic [LEN-1:0] shadow;

  // Preloading from active means the bit shifted out on the first cycle is
  // the active MSB, so an exact-length frame reads back the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (preload) begin
        shadow <= {active[LEN-2:0], sin};
      end else if (shift) begin
        shadow <= {shadow[LEN-2:0], sin};
      end
      if (commit) begin
        active <= shadow;
      end
    end
  end

  assign shadow_msb = shadow[LEN-1];

endmodule

// File: rtl/pattern_bank.sv
// NBUF double-buffered pattern buffers plus a sequence set, loaded bit-serially.
// Latency: field read 1 cycle; commit + load_done/load_err 1 cycle after ssel falls.
// Backpressure: none; frames are accepted every cycle ssel is high.
// Ports: sclk/rst_n; ssel/sin/saddr serial frame in, sout serial readback;
//        bufp/fieldp -> patternbyte registered read; pattern_sequence active
//        sequence fields; load_done/load_err one-cycle frame status pulses.
module pattern_bank
  import pattern_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int BUFSIZE = DEF_BUFSIZE,
  parameter int NBUF    = DEF_NBUF,
  parameter int NSEQ    = DEF_NSEQ,
  parameter int AW      = $clog2(NBUF + 1),
  parameter int FW      = $clog2(NSEQ + BUFSIZE)
) (
  input  logic                    sclk,
  input  logic                    rst_n,
  input  logic                    ssel,
  input  logic                    sin,
  input  logic [AW-1:0]           saddr,
  output logic                    sout,
  input  logic [$clog2(NBUF)-1:0] bufp,
  input  logic [FW-1:0]           fieldp,
  output logic [WIDTH-1:0]        patternbyte,
  output logic [NSEQ*WIDTH-1:0]   pattern_sequence,
  output logic                    load_done,
  output logic                    load_err
);

  localparam int BUF_LEN = BUFSIZE * WIDTH;
  localparam int SEQ_LEN = NSEQ * WIDTH;
  localparam int MAX_LEN = (BUF_LEN > SEQ_LEN) ? BUF_LEN : SEQ_LEN;
  // Counter must reach LEN+1 so over-length frames stay distinguishable.
  localparam int CW      = $clog2(MAX_LEN + 2);

  state_t          state, state_nxt;
  logic [AW-1:0]   tgt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   tgt_len;
  logic            start, shift_en, frame_end, commit_ok;
  logic [NBUF:0]   preload_v, shift_v, commit_v, act_msb, shd_msb;
  logic [BUF_LEN-1:0] buf_active [NBUF];
  logic [SEQ_LEN-1:0] seq_active;
  logic [WIDTH-1:0]   rd_dat;

  // State register
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ssel)  state_nxt = SHIFT;
      SHIFT:   if (!ssel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    start     = (state == IDLE) && ssel;
    shift_en  = (state == SHIFT) && ssel;
    frame_end = (state == SHIFT) && !ssel;
    tgt_len   = (int'(tgt) == NBUF) ? CW'(SEQ_LEN) : CW'(BUF_LEN);
    commit_ok = frame_end && (int'(tgt) <= NBUF) && (cnt == tgt_len);
    sout      = 1'b0;
    for (int i = 0; i <= NBUF; i++) begin
      preload_v[i] = start && (int'(saddr) == i);
      shift_v[i]   = shift_en && (int'(tgt) == i);
      commit_v[i]  = commit_ok && (int'(tgt) == i);
      // In the first cycle the latched target is not yet valid, so readback
      // comes straight from the addressed active copy.
      if (start && (int'(saddr) == i))          sout = act_msb[i];
      if ((state == SHIFT) && (int'(tgt) == i)) sout = shd_msb[i];
    end
  end

  // Target latch, bit counter and status pulses
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      tgt       <= '0;
      cnt       <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_done <= commit_ok;
      load_err  <= frame_end && !commit_ok;
      if (start) begin
        tgt <= saddr;
        cnt <= CW'(1);
      end else if (shift_en && (cnt != tgt_len + CW'(1))) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  for (genvar i = 0; i < NBUF; i++) begin : g_buf
    pattern_dbuf #(.LEN(BUF_LEN)) u_dbuf (
      .clk       (sclk),
      .rst_n     (rst_n),
      .preload   (preload_v[i]),
      .shift     (shift_v[i]),
      .commit    (commit_v[i]),
      .sin       (sin),
      .active    (buf_active[i]),
      .shadow_msb(shd_msb[i])
    );
    assign act_msb[i] = buf_active[i][BUF_LEN-1];
  end

  pattern_dbuf #(.LEN(SEQ_LEN)) u_seq (
    .clk       (sclk),
    .rst_n     (rst_n),
    .preload   (preload_v[NBUF]),
    .shift     (shift_v[NBUF]),
    .commit    (commit_v[NBUF]),
    .sin       (sin),
    .active    (seq_active),
    .shadow_msb(shd_msb[NBUF])
  );
  assign act_msb[NBUF]    = seq_active[SEQ_LEN-1];
  assign pattern_sequence = seq_active;

  // Field read mux: sequence fields first, then the selected buffer's fields;
  // anything past the last buffer field reads as zero.
  always_comb begin
    rd_dat = '0;
    for (int k = 0; k < NSEQ; k++) begin
      if (int'(fieldp) == k)
        rd_dat = seq_active[field_lsb(k, NSEQ, WIDTH) +: WIDTH];
    end
    for (int b = 0; b < NBUF; b++) begin
      for (int k = 0; k < BUFSIZE; k++) begin
        if ((int'(bufp) == b) && (int'(fieldp) == NSEQ + k))
          rd_dat = buf_active[b][field_lsb(k, BUFSIZE, WIDTH) +: WIDTH];
      end
    end
  end

  // Reads sample active before any same-cycle commit lands.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) patternbyte <= '0;
    else        patternbyte <= rd_dat;
  end

endmodule

// File: tb/tb_pattern_bank.sv
// Self-checking bench for pattern_bank: scoreboarded reads and status pulses.
// Latency: expects reads and pulses one cycle after stimulus.
// Backpressure: n/a.
module tb_pattern_bank;

  localparam int WIDTH = 8, BUFSIZE = 24, NBUF = 8, NSEQ = 3;
  localparam int AW = 4, FW = 5;
  localparam int BUF_LEN = BUFSIZE * WIDTH, SEQ_LEN = NSEQ * WIDTH;

  logic              sclk, rst_n, ssel, sin, sout, load_done, load_err;
  logic [AW-1:0]     saddr;
  logic [2:0]        bufp;
  logic [FW-1:0]     fieldp;
  logic [WIDTH-1:0]  patternbyte;
  logic [SEQ_LEN-1:0] pattern_sequence;

  pattern_bank dut (
    .sclk            (sclk),
    .rst_n           (rst_n),
    .ssel            (ssel),
    .sin             (sin),
    .saddr           (saddr),
    .sout            (sout),
    .bufp            (bufp),
    .fieldp          (fieldp),
    .patternbyte     (patternbyte),
    .pattern_sequence(pattern_sequence),
    .load_done       (load_done),
    .load_err        (load_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic [7:0]  mbuf [NBUF][BUFSIZE];
  logic [7:0]  mseq [NSEQ];
  logic [31:0] rd_q [$];
  logic [1:0]  pulse_q [$];
  bit          rd_live;
  int          n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_rd(input int b, input int f);
    if (f < NSEQ) return mseq[f];
    if (f < NSEQ + BUFSIZE) return mbuf[b][f-NSEQ];
    return 8'h00;
  endfunction

  function automatic logic [31:0] exp_seq();
    return {8'h00, mseq[0], mseq[1], mseq[2]};
  endfunction

  task automatic clear_model();
    for (int b = 0; b < NBUF; b++)
      for (int k = 0; k < BUFSIZE; k++) mbuf[b][k] = 8'h00;
    for (int k = 0; k < NSEQ; k++) mseq[k] = 8'h00;
  endtask

  // One cycle: at the falling edge, retire whatever the previous cycle queued.
  task automatic tick();
    logic [1:0] pe;
    @(negedge sclk);
    pe = (pulse_q.size() != 0) ? pulse_q.pop_front() : 2'b00;
    chk("pulse", {30'd0, load_done, load_err}, {30'd0, pe});
    if (rd_live) begin
      chk("rd", {24'd0, patternbyte}, rd_q.pop_front());
      rd_live = 1'b0;
    end
  endtask

  task automatic issue_rd(input int b, input int f);
    bufp   = 3'(b);
    fieldp = 5'(f);
    rd_q.push_back({24'd0, exp_rd(b, f)});
    rd_live = 1'b1;
  endtask

  task automatic sweep();
    for (int b = 0; b < NBUF; b++)
      for (int f = 0; f < 32; f++) begin
        issue_rd(b, f);
        tick();
      end
    chk("pseq", {8'd0, pattern_sequence}, exp_seq());
  endtask

  // Sends nbits of fr (MSB first from bit nbits-1); saddr is scrambled after
  // the first bit since the latched target must be used.
  task automatic send_frame(input int tgt, input int nbits, input logic [255:0] fr,
                            input bit chk_sout);
    logic [255:0] old;
    int len;
    bit commit;
    len = (tgt == NBUF) ? SEQ_LEN : BUF_LEN;
    old = '0;
    if (tgt < NBUF) for (int k = 0; k < BUFSIZE; k++) old = {old[247:0], mbuf[tgt][k]};
    else if (tgt == NBUF) for (int k = 0; k < NSEQ; k++) old = {old[247:0], mseq[k]};
    for (int i = 0; i < nbits; i++) begin
      ssel  = 1'b1;
      sin   = fr[nbits-1-i];
      saddr = (i == 0) ? 4'(tgt) : 4'($urandom_range(0, 15));
      #1;
      if (chk_sout && i < len) chk("sout", {31'd0, sout}, {31'd0, old[len-1-i]});
      tick();
    end
    ssel = 1'b0;
    sin  = 1'b0;
    commit = (nbits == len) && (tgt <= NBUF);
    pulse_q.push_back(commit ? 2'b10 : 2'b01);
    issue_rd(2, 3);  // commit-cycle read must see pre-commit contents
    if (commit) begin
      if (tgt < NBUF) for (int k = 0; k < BUFSIZE; k++) mbuf[tgt][k] = fr[nbits-1-8*k -: 8];
      else for (int k = 0; k < NSEQ; k++) mseq[k] = fr[nbits-1-8*k -: 8];
    end
    tick();
    chk("sout_idle", {31'd0, sout}, 32'd0);
    tick();
  endtask

  logic [255:0] fr;

  initial begin
    rst_n = 1'b0; ssel = 1'b0; sin = 1'b0; saddr = '0; bufp = '0; fieldp = '0;
    rd_live = 1'b0; n_chk = 0; n_err = 0;
    clear_model();
    repeat (3) tick();
    chk("rst_pb", {24'd0, patternbyte}, 32'd0);
    chk("rst_pseq", {8'd0, pattern_sequence}, 32'd0);
    chk("rst_sout", {31'd0, sout}, 32'd0);
    rst_n = 1'b1;
    tick();
    sweep();

    // Full buffer frame, fields A0..B7
    fr = '0;
    for (int k = 0; k < BUFSIZE; k++) fr = {fr[247:0], 8'(8'hA0 + k)};
    send_frame(2, 192, fr, 1'b0);
    issue_rd(2, 3);  tick();
    issue_rd(2, 26); tick();
    sweep();

    // Short, long and bad-target frames are rejected
    send_frame(2, 191, fr, 1'b0);
    send_frame(2, 193, fr, 1'b0);
    send_frame(9, 192, fr, 1'b0);
    issue_rd(2, 3); tick();

    // Sequence set, plus a short sequence frame
    send_frame(8, 24, 256'h112233, 1'b0);
    chk("pseq_load", {8'd0, pattern_sequence}, 32'h00112233);
    issue_rd(0, 1); tick();
    send_frame(8, 23, 256'h7f_ffff, 1'b0);
    chk("pseq_keep", {8'd0, pattern_sequence}, exp_seq());

    // Reload with zeros while checking readback of the old contents
    send_frame(2, 192, '0, 1'b1);
    issue_rd(2, 3); tick();
    sweep();

    // Reset in the middle of a frame to buffer 5
    for (int i = 0; i < 100; i++) begin
      ssel = 1'b1; saddr = 4'd5; sin = 1'($urandom);
      tick();
    end
    rst_n = 1'b0; ssel = 1'b0;
    clear_model();
    #1;
    chk("midrst_pb", {24'd0, patternbyte}, 32'd0);
    tick();
    chk("midrst_pseq", {8'd0, pattern_sequence}, 32'd0);
    rst_n = 1'b1;
    tick();
    sweep();
    fr = '0;
    for (int k = 0; k < BUFSIZE; k++) fr = {fr[247:0], 8'(8'h3C ^ (k * 7))};
    send_frame(5, 192, fr, 1'b1);
    sweep();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_bank.md
Name: pattern_bank

Overview:
Parametrised bank of NBUF pattern buffers plus one globally visible sequence register set, loaded over a bit-serial link. Each buffer is double-buffered: serial frames shift into a shadow copy and commit to the active copy atomically at frame end. The pattern engine therefore never sees a partially loaded buffer. The active copies feed a registered field read port used by the pattern sequencer.

Parameters:
WIDTH, 8, bits per field
BUFSIZE, 24, fields per pattern buffer
NBUF, 8, number of pattern buffers
NSEQ, 3, number of sequence fields (field addresses 0..NSEQ-1)
AW, $clog2(NBUF+1), width of saddr (target NBUF = sequence registers)
FW, $clog2(NSEQ+BUFSIZE), width of fieldp

Ports:
sclk  in  1  single clock, rising edge; also the serial bit clock
rst_n  in  1  asynchronous active-low reset
ssel  in  1  serial frame enable; high = frame in progress
sin  in  1  serial data in, MSB first
saddr  in  AW  serial target: 0..NBUF-1 buffer, NBUF sequence set
sout  out  1  serial readback of the target's current contents
bufp  in  $clog2(NBUF)  buffer selected for field reads
fieldp  in  FW  field address: <NSEQ sequence field, else buffer field fieldp-NSEQ
patternbyte  out  WIDTH  registered field read data
pattern_sequence  out  NSEQ*WIDTH  active sequence fields, field 0 in the top WIDTH bits
load_done  out  1  one-cycle pulse: frame committed
load_err  out  1  one-cycle pulse: frame rejected

Behaviour:
- Reset (async assert, sync deassert): all active/shadow storage, bit counter, latched target, patternbyte, load_done, load_err = 0; FSM -> IDLE.
- Frame length LEN = BUFSIZE*WIDTH for a buffer target and NSEQ*WIDTH for the sequence target. Flattened vector order: field 0 occupies the top WIDTH bits, field 0 MSB is sent first.
- FSM IDLE -> SHIFT, on the first cycle with ssel=1:
  - latch saddr to tgt;
  - shadow <= {active[tgt][LEN-2:0], sin};
  - cnt <= 1.
- SHIFT, while ssel=1:
  - shadow <= {shadow[LEN-2:0], sin};
  - cnt increments, saturating at LEN+1.
  - saddr changes during SHIFT are ignored.
- SHIFT -> IDLE on the first cycle with ssel=0 (no bit sampled in that cycle):
  - cnt==LEN and tgt<=NBUF: active[tgt] <= shadow; load_done=1 for that cycle.
  - otherwise (short, over-length, or tgt>NBUF): active is unchanged; load_err=1.
- sout:
  - in the IDLE->SHIFT cycle, MSB of active[saddr];
  - in SHIFT, shadow MSB;
  - in IDLE, 0.
  - An exact LEN-bit frame therefore reads back the previous contents.
- Field read, one-cycle latency: patternbyte <= the selected field.
  - fieldp<NSEQ selects sequence field fieldp.
  - NSEQ<=fieldp<NSEQ+BUFSIZE selects active[bufp] field fieldp-NSEQ.
  - Out-of-range fieldp returns 0.
- Commit and read in the same cycle: the read returns the pre-commit value; the new value is visible on the next read.
- pattern_sequence is driven directly from active sequence storage and changes only in the commit cycle (+0 latency from the register).
- Reset asserted mid-frame aborts the frame: no commit, no pulse.

Decomposition:
- Package pattern_pkg: default WIDTH/BUFSIZE/NBUF/NSEQ constants, FSM state enum {IDLE, SHIFT}, and a field-index function returning the bit offset of field k.
- Sub-module pattern_dbuf: one double-buffered register (shadow shift register, active copy, commit strobe, preload from active). Instantiate NBUF+1 times, the sequence set with length NSEQ*WIDTH.
- The top level holds the FSM, bit counter, target decode and read mux.

Test Plan:
- Reset, then read fieldp=0..26 of every buffer -> patternbyte=0; pattern_sequence=0; sout=0.
- Frame saddr=2 with 192 bits, fields 0xA0..0xB7 -> load_done pulse one cycle after ssel falls; bufp=2, fieldp=3 -> patternbyte=0xA0 next cycle, fieldp=26 -> 0xB7; other buffers remain 0.
- Frame saddr=2 with 191 bits, then 193 bits -> load_err pulse each time; buffer 2 still reads 0xA0..0xB7.
- Frame saddr=8 with 24 bits 0x11,0x22,0x33 -> pattern_sequence=0x112233; fieldp=1 -> patternbyte=0x22.
- Reload buffer 2 with 192 bits of 0x00 and check sout -> the serial stream equals the previous 0xA0..0xB7 bits MSB first; commit cycle read of bufp=2, fieldp=3 -> 0xA0, next read -> 0x00.
- Assert rst_n=0 after 100 bits of a frame to buffer 5 -> no pulse; after release, buffer 5 reads 0 and a new full frame commits normally.
